// File: rtl/ped_request_ctrl.sv
// -----------------------------------------------------------------------------
// ped_request_ctrl
//   Pedestrian push-button front end for the crossing light controller.
//   The raw button is synchronised and debounced. Each clean rising edge
//   becomes at most one crossing request, which is offered to the light FSM
//   over a valid/ack handshake. After a served request, a hold-off window
//   ignores further presses. A saturating 8-bit counter records served
//   requests for the display.
//
// Ports
//   clk_in        in   system clock
//   rst           in   asynchronous reset, active-low
//   btn_raw       in   raw push-button level (asynchronous, bouncing)
//   req_ack       in   FSM accepts the request (only sampled while req_valid)
//   req_valid     out  crossing request outstanding
//   btn_clean     out  debounced button level
//   req_pending   out  LED: request pending or hold-off running
//   press_dropped out  one-cycle pulse: a clean press was merged or ignored
//   served_count  out  number of acknowledged requests, saturates at 255
// -----------------------------------------------------------------------------
module ped_request_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd2000000,
   parameter int unsigned HOLDOFF_CYCLES  = 32'd100000000,
   parameter int unsigned CNT_W           = 32'd27
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic       req_ack,
   output logic       req_valid,
   output logic       btn_clean,
   output logic       req_pending,
   output logic       press_dropped,
   output logic [7:0] served_count
);

   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] HO_LAST    = (HOLDOFF_CYCLES == 32'd0) ? '0
                                             : CNT_W'(HOLDOFF_CYCLES - 32'd1);
   localparam bit               HOLDOFF_EN = (HOLDOFF_CYCLES != 32'd0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   // Saturating increment for the served-request counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

   logic             sync1_q;
   logic             sync2_q;
   logic             btn_clean_q;
   logic             btn_clean_d;
   logic             clean_dly_q;
   logic [CNT_W-1:0] db_cnt_q;
   logic [CNT_W-1:0] db_cnt_d;
   logic             press_s;

   state_e           state_q;
   logic [CNT_W-1:0] ho_cnt_q;
   logic             req_valid_q;
   logic             req_pending_q;
   logic             press_dropped_q;
   logic [7:0]       served_q;

   // Two-flop synchroniser; btn_raw is not used anywhere else.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next-state: count cycles of disagreement, restart on agreement.
   always_comb begin
      db_cnt_d    = '0;
      btn_clean_d = btn_clean_q;
      if (sync2_q == btn_clean_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         btn_clean_d = sync2_q;
         db_cnt_d    = '0;
      end else begin
         db_cnt_d = db_cnt_q + CNT_W'(1);
      end
   end

   // Debounce state plus a delayed copy of the clean level for edge detection.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         db_cnt_q    <= '0;
         btn_clean_q <= 1'b0;
         clean_dly_q <= 1'b0;
      end else begin
         db_cnt_q    <= db_cnt_d;
         btn_clean_q <= btn_clean_d;
         clean_dly_q <= btn_clean_q;
      end
   end

   assign press_s = btn_clean_q & ~clean_dly_q;

   // Request FSM with registered handshake, LED, drop pulse and served counter.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         ho_cnt_q        <= '0;
         req_valid_q     <= 1'b0;
         req_pending_q   <= 1'b0;
         press_dropped_q <= 1'b0;
         served_q        <= 8'd0;
      end else begin
         press_dropped_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (press_s) begin
                  state_q       <= ST_PENDING;
                  req_valid_q   <= 1'b1;
                  req_pending_q <= 1'b1;
               end else begin
                  req_valid_q   <= 1'b0;
                  req_pending_q <= 1'b0;
               end
            end
            ST_PENDING: begin
               // A press here is merged into the outstanding request.
               press_dropped_q <= press_s;
               if (req_ack) begin
                  req_valid_q <= 1'b0;
                  served_q    <= sat_inc8(served_q);
                  ho_cnt_q    <= '0;
                  if (HOLDOFF_EN) begin
                     state_q       <= ST_HOLDOFF;
                     req_pending_q <= 1'b1;
                  end else begin
                     state_q       <= ST_IDLE;
                     req_pending_q <= 1'b0;
                  end
               end else begin
                  req_valid_q   <= 1'b1;
                  req_pending_q <= 1'b1;
               end
            end
            ST_HOLDOFF: begin
               // Presses are discarded, including on the exit cycle.
               press_dropped_q <= press_s;
               req_valid_q     <= 1'b0;
               if (ho_cnt_q == HO_LAST) begin
                  state_q       <= ST_IDLE;
                  ho_cnt_q      <= '0;
                  req_pending_q <= 1'b0;
               end else begin
                  ho_cnt_q      <= ho_cnt_q + CNT_W'(1);
                  req_pending_q <= 1'b1;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               ho_cnt_q      <= '0;
               req_valid_q   <= 1'b0;
               req_pending_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_valid     = req_valid_q;
   assign btn_clean     = btn_clean_q;
   assign req_pending   = req_pending_q;
   assign press_dropped = press_dropped_q;
   assign served_count  = served_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ped_request_ctrl
//   Self-checking bench for ped_request_ctrl (DEBOUNCE_CYCLES=4,
//   HOLDOFF_CYCLES=8). A behavioural model tracks the expected outputs every
//   cycle; a vector table and hand-written sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_ped_request_ctrl;

   localparam int D = 4;
   localparam int H = 8;

   logic       clk_s = 1'b0;
   logic       rst_s;
   logic       btn_raw_s;
   logic       req_ack_s;
   logic       req_valid_s;
   logic       btn_clean_s;
   logic       req_pending_s;
   logic       press_dropped_s;
   logic [7:0] served_count_s;

   int errors = 0;
   int checks = 0;
   int drop_seen = 0;
   int valid_rise = 0;
   logic prev_valid = 1'b0;

   // behavioural model state
   logic m_rq[$];
   logic m_clean, m_prev;
   int   m_run, m_mode, m_left, m_served;
   logic m_drop;

   ped_request_ctrl #(
      .DEBOUNCE_CYCLES(32'd4),
      .HOLDOFF_CYCLES (32'd8),
      .CNT_W          (32'd8)
   ) dut (
      .clk_in       (clk_s),
      .rst          (rst_s),
      .btn_raw      (btn_raw_s),
      .req_ack      (req_ack_s),
      .req_valid    (req_valid_s),
      .btn_clean    (btn_clean_s),
      .req_pending  (req_pending_s),
      .press_dropped(press_dropped_s),
      .served_count (served_count_s)
   );

   always #5 clk_s = ~clk_s;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rq = {};
      m_rq.push_back(1'b0);
      m_rq.push_back(1'b0);
      m_clean = 1'b0; m_prev = 1'b0; m_run = 0;
      m_mode = 0; m_left = 0; m_served = 0; m_drop = 1'b0;
   endtask

   // Model: the button level seen two cycles late must disagree with the
   // clean level for D consecutive cycles before the clean level follows.
   // Modes: 0 idle, 1 request outstanding, 2 hold-off with cycles left.
   task automatic model_step();
      logic delayed, press;
      delayed = m_rq[0];
      m_rq.push_back(btn_raw_s);
      void'(m_rq.pop_front());
      press  = m_clean && !m_prev;
      m_prev = m_clean;
      if (delayed != m_clean) begin
         m_run++;
         if (m_run == D) begin
            m_clean = delayed;
            m_run   = 0;
         end
      end else begin
         m_run = 0;
      end
      m_drop = 1'b0;
      if (m_mode == 0) begin
         if (press) m_mode = 1;
      end else if (m_mode == 1) begin
         if (press) m_drop = 1'b1;
         if (req_ack_s) begin
            m_served = (m_served < 255) ? m_served + 1 : 255;
            m_left   = H;
            m_mode   = (H == 0) ? 0 : 2;
         end
      end else begin
         if (press) m_drop = 1'b1;
         m_left--;
         if (m_left == 0) m_mode = 0;
      end
   endtask

   // One clock: model advances on the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk_s);
      if (!rst_s) model_reset();
      else model_step();
      @(negedge clk_s);
      chk("mdl_btn_clean", {7'd0, btn_clean_s}, {7'd0, m_clean});
      chk("mdl_req_valid", {7'd0, req_valid_s}, {7'd0, logic'(m_mode == 1)});
      chk("mdl_req_pending", {7'd0, req_pending_s}, {7'd0, logic'(m_mode != 0)});
      chk("mdl_press_dropped", {7'd0, press_dropped_s}, {7'd0, m_drop});
      chk("mdl_served_count", served_count_s, 8'(m_served));
      if (press_dropped_s) drop_seen++;
      if (req_valid_s && !prev_valid) valid_rise++;
      prev_valid = req_valid_s;
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic wait_valid(input int max_cyc, input string name);
      logic found;
      found = 1'b0;
      for (int k = 0; k < max_cyc && !found; k++) begin
         cycle();
         if (req_valid_s) found = 1'b1;
      end
      chk(name, {7'd0, found}, 8'd1);
   endtask

   typedef struct {
      logic       raw;
      logic       ack;
      int         n;
      logic       e_clean;
      logic       e_valid;
      logic       e_pend;
      logic [7:0] e_served;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int d0, r0, hold;

      tbl[0] = '{1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[1] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b1, 8'd0};
      tbl[3] = '{1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b1, 8'd0};
      tbl[4] = '{1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1, 8'd1};
      tbl[5] = '{1'b1, 1'b0,  7, 1'b1, 1'b0, 1'b1, 8'd1};
      tbl[6] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[7] = '{1'b1, 1'b0,  5, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[8] = '{1'b0, 1'b0,  5, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[9] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 8'd1};

      // reset with the button already held
      rst_s = 1'b0; btn_raw_s = 1'b1; req_ack_s = 1'b0;
      model_reset();
      @(negedge clk_s);
      chk("rst_req_valid", {7'd0, req_valid_s}, 8'd0);
      chk("rst_btn_clean", {7'd0, btn_clean_s}, 8'd0);
      chk("rst_req_pending", {7'd0, req_pending_s}, 8'd0);
      chk("rst_press_dropped", {7'd0, press_dropped_s}, 8'd0);
      chk("rst_served", served_count_s, 8'd0);
      rst_s = 1'b1;

      // table: debounce latency, request, long handshake, ack, hold-off, release
      d0 = drop_seen;
      for (int i = 0; i < 10; i++) begin
         btn_raw_s = tbl[i].raw;
         req_ack_s = tbl[i].ack;
         cycles(tbl[i].n);
         chk($sformatf("tbl%0d_clean", i), {7'd0, btn_clean_s}, {7'd0, tbl[i].e_clean});
         chk($sformatf("tbl%0d_valid", i), {7'd0, req_valid_s}, {7'd0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_pending", i), {7'd0, req_pending_s}, {7'd0, tbl[i].e_pend});
         chk($sformatf("tbl%0d_served", i), served_count_s, tbl[i].e_served);
      end
      chk("tbl_no_drops", 8'(drop_seen - d0), 8'd0);

      // bounce: toggle every 2 cycles for 20 cycles, then hold high
      d0 = drop_seen; r0 = valid_rise;
      for (int i = 0; i < 20; i++) begin
         btn_raw_s = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
         cycle();
      end
      btn_raw_s = 1'b1;
      cycles(5);
      chk("bounce_clean_early", {7'd0, btn_clean_s}, 8'd0);
      cycle();
      chk("bounce_clean_rise", {7'd0, btn_clean_s}, 8'd1);
      cycle();
      chk("bounce_valid", {7'd0, req_valid_s}, 8'd1);
      chk("bounce_one_request", 8'(valid_rise - r0), 8'd1);
      chk("bounce_no_drop", 8'(drop_seen - d0), 8'd0);

      // merge: second clean press while the request is outstanding
      d0 = drop_seen;
      btn_raw_s = 1'b0; cycles(7);
      btn_raw_s = 1'b1; cycles(7);
      chk("merge_drop", 8'(drop_seen - d0), 8'd1);
      chk("merge_valid", {7'd0, req_valid_s}, 8'd1);
      btn_raw_s = 1'b0; cycles(7);
      // ack, and a press that matures inside the hold-off window
      d0 = drop_seen; r0 = valid_rise;
      btn_raw_s = 1'b1; req_ack_s = 1'b1; cycle();
      req_ack_s = 1'b0; cycles(12);
      chk("holdoff_drop", 8'(drop_seen - d0), 8'd1);
      chk("holdoff_no_request", 8'(valid_rise - r0), 8'd0);
      chk("holdoff_valid", {7'd0, req_valid_s}, 8'd0);
      chk("holdoff_idle", {7'd0, req_pending_s}, 8'd0);
      chk("merge_served", served_count_s, 8'd2);

      // saturation: 260 more request/ack rounds
      for (int i = 0; i < 260; i++) begin
         btn_raw_s = 1'b0; cycles(7);
         btn_raw_s = 1'b1;
         wait_valid(12, "sat_wait_valid");
         req_ack_s = 1'b1; cycle();
         req_ack_s = 1'b0;
         chk("sat_count", served_count_s, (i + 3 > 255) ? 8'd255 : 8'(i + 3));
         cycles(9);
      end
      chk("sat_final", served_count_s, 8'd255);

      // ack while idle must be ignored
      req_ack_s = 1'b1; cycles(3); req_ack_s = 1'b0;
      chk("idle_ack_served", served_count_s, 8'd255);
      chk("idle_ack_state", {7'd0, req_pending_s}, 8'd0);

      // random stimulus against the model
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            btn_raw_s = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 14));
         end
         hold--;
         req_ack_s = ($urandom_range(0, 3) == 0);
         cycle();
      end

      // drain to idle
      btn_raw_s = 1'b0; req_ack_s = 1'b0; cycles(10);
      req_ack_s = 1'b1; cycle();
      req_ack_s = 1'b0; cycles(10);
      chk("drain_idle", {7'd0, req_pending_s}, 8'd0);

      // asynchronous reset while a request is outstanding
      btn_raw_s = 1'b1;
      wait_valid(20, "arst_wait_valid");
      #2 rst_s = 1'b0;
      #1;
      chk("arst_req_valid", {7'd0, req_valid_s}, 8'd0);
      chk("arst_served", served_count_s, 8'd0);
      chk("arst_pending", {7'd0, req_pending_s}, 8'd0);
      chk("arst_clean", {7'd0, btn_clean_s}, 8'd0);
      cycles(3);
      rst_s = 1'b1;
      wait_valid(20, "post_rst_wait_valid");
      req_ack_s = 1'b1; cycle();
      req_ack_s = 1'b0;
      chk("post_rst_served", served_count_s, 8'd1);
      cycles(10);
      chk("post_rst_idle", {7'd0, req_pending_s}, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
